seg7_byte_decoder: RTL and testbench

- Reverse path of the hex display encoder. Accepts a stream of active-low 7-segment codes, one digit per strobe, high nibble first.
- Decodes each code back to a nibble and assembles pairs into an 8-bit byte.
- Flags illegal codes and incomplete pairs.
- Used to check display traffic in loopback and to recover operands from captured segment buses.

---
 rtl/seg7_byte_decoder.sv | 167 ++++++++++++++++
 tb/tb_seg7_byte_decoder.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_byte_decoder.sv
// Decodes a stream of active-low 7-segment digit codes (high nibble first) back into bytes,
// flagging illegal codes and abandoned pairs. Optional macro SEG7_DECODE_BLANK_EN accepts a blank high digit.
module seg7_byte_decoder #(
    parameter int TIMEOUT = 1000,
    parameter int ERR_W   = 8
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic [0:6]       seg_in,
    input  logic             seg_valid,
    output logic [7:0]       byte_out,
    output logic             byte_valid,
    output logic             code_err,
    output logic             timeout,
    output logic             busy,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic [0:0] {
        ST_WAIT_HI = 1'b0,
        ST_WAIT_LO = 1'b1
    } state_t;

    localparam int                 TIMER_W    = 20;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);
    localparam logic [ERR_W-1:0]   ERR_MAX    = {ERR_W{1'b1}};

    // Returns {legal, nibble}; seg_in[0] is segment a, a 0 bit means the segment is lit.
    function automatic logic [4:0] decode_seg(input logic [0:6] code);
        logic [4:0] result;
        case (code)
            7'b0000001: result = 5'b1_0000;
            7'b1001111: result = 5'b1_0001;
            7'b0010010: result = 5'b1_0010;
            7'b0000110: result = 5'b1_0011;
            7'b1001100: result = 5'b1_0100;
            7'b0100100: result = 5'b1_0101;
            7'b0100000: result = 5'b1_0110;
            7'b0001111: result = 5'b1_0111;
            7'b0000000: result = 5'b1_1000;
            7'b0000100: result = 5'b1_1001;
            7'b0001000: result = 5'b1_1010;
            7'b1100000: result = 5'b1_1011;
            7'b0110001: result = 5'b1_1100;
            7'b1000010: result = 5'b1_1101;
            7'b0110000: result = 5'b1_1110;
            7'b0111000: result = 5'b1_1111;
            default:    result = 5'b0_0000;
        endcase
        return result;
    endfunction

    state_t             state_q, state_d;
    logic [3:0]         hi_q, hi_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [7:0]         byte_q, byte_d;
    logic               byte_valid_q, byte_valid_d;
    logic               code_err_q, code_err_d;
    logic               timeout_q, timeout_d;
    logic [ERR_W-1:0]   err_q, err_d;

    logic [4:0]         dec_s;
    logic               lo_ok_s;
    logic               hi_ok_s;
    logic [3:0]         nib_s;

    // Code legality; a blank digit decodes to nibble 0 and may only lead a pair.
    always_comb begin
        dec_s   = decode_seg(seg_in);
        lo_ok_s = dec_s[4];
        nib_s   = dec_s[3:0];
`ifdef SEG7_DECODE_BLANK_EN
        hi_ok_s = dec_s[4] | (seg_in == 7'b1111111);
`else
        hi_ok_s = dec_s[4];
`endif
    end

    // Next-state and pulse logic; a strobe always takes priority over the timeout check.
    always_comb begin
        state_d      = state_q;
        hi_d         = hi_q;
        timer_d      = timer_q;
        byte_d       = byte_q;
        byte_valid_d = 1'b0;
        code_err_d   = 1'b0;
        timeout_d    = 1'b0;
        case (state_q)
            ST_WAIT_HI: begin
                if (seg_valid) begin
                    if (hi_ok_s) begin
                        hi_d    = nib_s;
                        timer_d = '0;
                        state_d = ST_WAIT_LO;
                    end else begin
                        code_err_d = 1'b1;
                    end
                end else begin
                    state_d = ST_WAIT_HI;
                end
            end
            ST_WAIT_LO: begin
                if (seg_valid) begin
                    if (lo_ok_s) begin
                        byte_d       = {hi_q, nib_s};
                        byte_valid_d = 1'b1;
                    end else begin
                        code_err_d = 1'b1;
                        hi_d       = 4'h0;
                    end
                    state_d = ST_WAIT_HI;
                end else if (timer_q == TIMER_LAST) begin
                    timeout_d = 1'b1;
                    hi_d      = 4'h0;
                    state_d   = ST_WAIT_HI;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            default: begin
                state_d = ST_WAIT_HI;
                hi_d    = 4'h0;
                timer_d = '0;
            end
        endcase
    end

    // Saturating error counter fed by the two error pulses (never both in one cycle).
    always_comb begin
        if ((code_err_d || timeout_d) && (err_q != ERR_MAX)) begin
            err_d = err_q + ERR_W'(1);
        end else begin
            err_d = err_q;
        end
    end

    // State and output registers.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q      <= ST_WAIT_HI;
            hi_q         <= 4'h0;
            timer_q      <= '0;
            byte_q       <= 8'h00;
            byte_valid_q <= 1'b0;
            code_err_q   <= 1'b0;
            timeout_q    <= 1'b0;
            err_q        <= '0;
        end else begin
            state_q      <= state_d;
            hi_q         <= hi_d;
            timer_q      <= timer_d;
            byte_q       <= byte_d;
            byte_valid_q <= byte_valid_d;
            code_err_q   <= code_err_d;
            timeout_q    <= timeout_d;
            err_q        <= err_d;
        end
    end

    assign byte_out   = byte_q;
    assign byte_valid = byte_valid_q;
    assign code_err   = code_err_q;
    assign timeout    = timeout_q;
    assign busy       = (state_q == ST_WAIT_LO);
    assign err_count  = err_q;

endmodule

// File: tb/tb_seg7_byte_decoder.sv
// Bench for seg7_byte_decoder: directed vector table, hand sequences for timeout/reset/saturation,
// and randomized strobes against a behavioural pair-assembly model.
module tb_seg7_byte_decoder;

    localparam int TIMEOUT = 10;
    localparam int ERR_W   = 2;
    localparam int ERR_MAX = (1 << ERR_W) - 1;
`ifdef SEG7_DECODE_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif

    localparam logic [0:6] C0    = 7'b0000001;
    localparam logic [0:6] C1    = 7'b1001111;
    localparam logic [0:6] C2    = 7'b0010010;
    localparam logic [0:6] C4    = 7'b1001100;
    localparam logic [0:6] C5    = 7'b0100100;
    localparam logic [0:6] C6    = 7'b0100000;
    localparam logic [0:6] C7    = 7'b0001111;
    localparam logic [0:6] C8    = 7'b0000000;
    localparam logic [0:6] C9    = 7'b0000100;
    localparam logic [0:6] CC    = 7'b0110001;
    localparam logic [0:6] CF    = 7'b0111000;
    localparam logic [0:6] BAD   = 7'b1111110;
    localparam logic [0:6] BLANK = 7'b1111111;

    logic             CLK = 1'b0;
    logic             reset = 1'b1;
    logic [0:6]       seg_in = 7'b1111111;
    logic             seg_valid = 1'b0;
    logic [7:0]       byte_out;
    logic             byte_valid;
    logic             code_err;
    logic             timeout;
    logic             busy;
    logic [ERR_W-1:0] err_count;

    int errors = 0;
    int checks = 0;

    seg7_byte_decoder #(.TIMEOUT(TIMEOUT), .ERR_W(ERR_W)) dut (
        .CLK(CLK), .reset(reset), .seg_in(seg_in), .seg_valid(seg_valid),
        .byte_out(byte_out), .byte_valid(byte_valid), .code_err(code_err),
        .timeout(timeout), .busy(busy), .err_count(err_count)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Digit glyph table, index = nibble value.
    logic [0:6] glyph [16];
    initial begin
        glyph[0]  = 7'b0000001; glyph[1]  = 7'b1001111; glyph[2]  = 7'b0010010; glyph[3]  = 7'b0000110;
        glyph[4]  = 7'b1001100; glyph[5]  = 7'b0100100; glyph[6]  = 7'b0100000; glyph[7]  = 7'b0001111;
        glyph[8]  = 7'b0000000; glyph[9]  = 7'b0000100; glyph[10] = 7'b0001000; glyph[11] = 7'b1100000;
        glyph[12] = 7'b0110001; glyph[13] = 7'b1000010; glyph[14] = 7'b0110000; glyph[15] = 7'b0111000;
    end

    // Reference model: a pending high digit, an idle-cycle count and the last assembled byte.
    bit         m_pending;
    int         m_hi;
    int         m_idle;
    int         m_err;
    logic [7:0] m_byte;
    bit         m_bv, m_ce, m_to;

    function automatic int glyph_value(input logic [0:6] c);
        int val = -1;
        for (int i = 0; i < 16; i++) begin
            if (glyph[i] == c) val = i;
        end
        return val;
    endfunction

    function automatic void model_reset();
        m_pending = 1'b0; m_hi = 0; m_idle = 0; m_err = 0;
        m_byte = 8'h00; m_bv = 1'b0; m_ce = 1'b0; m_to = 1'b0;
    endfunction

    function automatic void model_error();
        if (m_err < ERR_MAX) m_err = m_err + 1;
    endfunction

    function automatic void model_edge(input logic v, input logic [0:6] c);
        int val;
        val = glyph_value(c);
        m_bv = 1'b0; m_ce = 1'b0; m_to = 1'b0;
        if (v) begin
            if (!m_pending) begin
                if (BLANK_EN && c == BLANK) val = 0;
                if (val >= 0) begin
                    m_pending = 1'b1; m_hi = val; m_idle = 0;
                end else begin
                    m_ce = 1'b1; model_error();
                end
            end else begin
                m_pending = 1'b0;
                if (val >= 0) begin
                    m_byte = 8'(m_hi * 16 + val); m_bv = 1'b1;
                end else begin
                    m_ce = 1'b1; model_error();
                end
            end
        end else if (m_pending) begin
            m_idle = m_idle + 1;
            if (m_idle == TIMEOUT) begin
                m_pending = 1'b0; m_to = 1'b1; model_error();
            end
        end
    endfunction

    task automatic check_exp(input string name, input logic [7:0] eb, input logic ebv, input logic ece,
                             input logic eto, input logic ebusy, input logic [ERR_W-1:0] eerr);
        checks++;
        if ({byte_out, byte_valid, code_err, timeout, busy, err_count} !== {eb, ebv, ece, eto, ebusy, eerr}) begin
            errors++;
            $display("FAIL %s: got byte=%02h bv=%b ce=%b to=%b busy=%b err=%0d, expected byte=%02h bv=%b ce=%b to=%b busy=%b err=%0d",
                     name, byte_out, byte_valid, code_err, timeout, busy, err_count,
                     eb, ebv, ece, eto, ebusy, eerr);
        end
    endtask

    task automatic check_model(input string name);
        check_exp(name, m_byte, m_bv, m_ce, m_to, m_pending, ERR_W'(m_err));
    endtask

    task automatic step(input logic v, input logic [0:6] c);
        seg_valid = v;
        seg_in    = c;
        @(posedge CLK);
        #1;
        model_edge(v, c);
        seg_valid = 1'b0;
    endtask

    task automatic do_reset();
        seg_valid = 1'b0;
        @(negedge CLK);
        reset = 1'b1;
        #1;
        model_reset();
        check_exp("reset_async", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        @(negedge CLK);
        reset = 1'b0;
    endtask

    typedef struct {
        logic             v;
        logic [0:6]       code;
        logic [7:0]       eb;
        logic             ebv, ece, eto, ebusy;
        logic [ERR_W-1:0] eerr;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic v, input logic [0:6] code, input logic [7:0] eb, input logic ebv,
                                input logic ece, input logic ebusy, input logic [ERR_W-1:0] eerr);
        vec_t r;
        r.v = v; r.code = code; r.eb = eb; r.ebv = ebv; r.ece = ece; r.eto = 1'b0;
        r.ebusy = ebusy; r.eerr = eerr;
        vecs.push_back(r);
    endfunction

    initial begin
        logic [7:0] last_b;

        // Directed vectors, applied from reset (TIMEOUT never reached here).
        add(1'b1, C2,  8'h00, 1'b0, 1'b0, 1'b1, 2'd0);
        add(1'b0, C0,  8'h00, 1'b0, 1'b0, 1'b1, 2'd0);
        add(1'b0, C0,  8'h00, 1'b0, 1'b0, 1'b1, 2'd0);
        add(1'b1, CC,  8'h2C, 1'b1, 1'b0, 1'b0, 2'd0);
        add(1'b0, C0,  8'h2C, 1'b0, 1'b0, 1'b0, 2'd0);
        add(1'b1, BAD, 8'h2C, 1'b0, 1'b1, 1'b0, 2'd1);
        add(1'b1, C7,  8'h2C, 1'b0, 1'b0, 1'b1, 2'd1);
        add(1'b1, C1,  8'h71, 1'b1, 1'b0, 1'b0, 2'd1);
        add(1'b1, CF,  8'h71, 1'b0, 1'b0, 1'b1, 2'd1);
        add(1'b1, CF,  8'hFF, 1'b1, 1'b0, 1'b0, 2'd1);
        add(1'b1, C0,  8'hFF, 1'b0, 1'b0, 1'b1, 2'd1);
        add(1'b1, C1,  8'h01, 1'b1, 1'b0, 1'b0, 2'd1);
        add(1'b0, C0,  8'h01, 1'b0, 1'b0, 1'b0, 2'd1);
        add(1'b1, C9,  8'h01, 1'b0, 1'b0, 1'b1, 2'd1);
        add(1'b1, BAD, 8'h01, 1'b0, 1'b1, 1'b0, 2'd2);
        add(1'b1, C5,  8'h01, 1'b0, 1'b0, 1'b1, 2'd2);
        add(1'b1, C4,  8'h54, 1'b1, 1'b0, 1'b0, 2'd2);
`ifdef SEG7_DECODE_BLANK_EN
        add(1'b1, BLANK, 8'h54, 1'b0, 1'b0, 1'b1, 2'd2);
        add(1'b1, C6,    8'h06, 1'b1, 1'b0, 1'b0, 2'd2);
        add(1'b1, C6,    8'h06, 1'b0, 1'b0, 1'b1, 2'd2);
        add(1'b1, BLANK, 8'h06, 1'b0, 1'b1, 1'b0, 2'd3);
        last_b = 8'h06;
`else
        add(1'b1, BLANK, 8'h54, 1'b0, 1'b1, 1'b0, 2'd3);
        add(1'b1, C6,    8'h54, 1'b0, 1'b0, 1'b1, 2'd3);
        add(1'b1, BLANK, 8'h54, 1'b0, 1'b1, 1'b0, 2'd3);
        last_b = 8'h54;
`endif
        add(1'b1, BAD, last_b, 1'b0, 1'b1, 1'b0, 2'd3);
        add(1'b0, C0,  last_b, 1'b0, 1'b0, 1'b0, 2'd3);

        do_reset();
        foreach (vecs[i]) begin
            step(vecs[i].v, vecs[i].code);
            check_exp($sformatf("vec%0d", i), vecs[i].eb, vecs[i].ebv, vecs[i].ece,
                      vecs[i].eto, vecs[i].ebusy, vecs[i].eerr);
        end

        // Abandoned pair: timeout exactly TIMEOUT idle cycles after the high digit.
        do_reset();
        step(1'b1, C8);
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            step(1'b0, C0);
            check_model("to_wait");
        end
        step(1'b0, C0);
        check_exp("timeout_pulse", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1);
        step(1'b0, C0);
        check_exp("timeout_one_cycle", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
        step(1'b1, C9);
        step(1'b1, C9);
        check_exp("pair_99", 8'h99, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);

        // Low strobe landing on the timeout cycle wins.
        do_reset();
        step(1'b1, C2);
        for (int i = 0; i < TIMEOUT - 1; i++) step(1'b0, C0);
        step(1'b1, C1);
        check_exp("strobe_wins", 8'h21, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);

        // Reset mid-pair drops the pending nibble.
        do_reset();
        step(1'b1, C5);
        check_model("mid_pair_busy");
        do_reset();
        step(1'b1, C4);
        check_exp("after_reset_hi", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
        step(1'b0, C0);
        check_exp("after_reset_idle", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);

        // Counter saturation.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, BAD);
            check_exp($sformatf("err_sat%0d", i), 8'h00, 1'b0, 1'b1, 1'b0, 1'b0,
                      (i < ERR_MAX) ? ERR_W'(i + 1) : ERR_W'(ERR_MAX));
        end

        // Randomized strobes against the model.
        do_reset();
        for (int n = 0; n < 600; n++) begin
            int sel;
            logic [0:6] c;
            sel = $urandom_range(0, 9);
            if (sel < 6)       c = glyph[$urandom_range(0, 15)];
            else if (sel < 8)  c = BLANK;
            else               c = 7'($urandom);
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
            end else if ($urandom_range(0, 19) == 0) begin
                int gap;
                gap = $urandom_range(TIMEOUT - 2, TIMEOUT + 2);
                for (int k = 0; k < gap; k++) begin
                    step(1'b0, c);
                    check_model("rand_idle");
                end
            end else begin
                step(($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0, c);
                check_model("rand");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
